adc_scan_ctrl: RTL and testbench

- SPI master and channel sequencer for the 8-channel serial ADC used for PMSM phase current and voltage sensing.
- On a start pulse, for example the PWM-center sync, it converts every channel enabled in a mask, in ascending index order, with one chip-select frame per channel.
- Each result is emitted as a channel/data strobe; a done pulse closes the scan.
- Downstream current/voltage processing consumes the strobes.

---
 rtl/adc_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - SPI master and channel sequencer for an 8-channel serial ADC
module adc_scan_ctrl #(
  parameter int ADC_N    = 8,
  parameter int ADC_W    = 12,
  parameter int SCLK_DIV = 4,
  parameter int CS_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADC_N-1:0] ch_mask,
  output logic             busy,
  output logic             adc_sclk,
  output logic             adc_css,
  output logic             adc_din,
  input  logic             adc_dout,
  output logic [ADC_W-1:0] res_data,
  output logic [2:0]       res_ch,
  output logic             res_valid,
  output logic             scan_done
);

  localparam int HW = $clog2(SCLK_DIV);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [4:0]    BIT_LAST  = 5'(ADC_W + 4);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t           r_state, w_state_nxt;
  logic [HW-1:0]    r_hcnt, w_hcnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic [4:0]       r_bit, w_bit_nxt;
  logic [GW-1:0]    r_gcnt, w_gcnt_nxt;
  logic [ADC_N-1:0] r_mask, w_mask_nxt;
  logic [2:0]       r_addr, w_addr_nxt;
  logic [ADC_W-1:0] r_shift, w_shift_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_css, w_css_nxt;
  logic             r_din, w_din_nxt;
  logic [ADC_W-1:0] r_res_data, w_res_data_nxt;
  logic [2:0]       r_res_ch, w_res_ch_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic             w_scan_done;
  logic [3:0]       w_first, w_next;

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [3:0] find_ch(input logic [ADC_N-1:0] mask, input logic [3:0] lo);
    logic [3:0] r;
    r = 4'd0;
    for (int i = ADC_N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(lo))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_hcnt_nxt      = r_hcnt;
    w_phase_nxt     = r_phase;
    w_bit_nxt       = r_bit;
    w_gcnt_nxt      = r_gcnt;
    w_mask_nxt      = r_mask;
    w_addr_nxt      = r_addr;
    w_shift_nxt     = r_shift;
    w_sclk_nxt      = r_sclk;
    w_css_nxt       = r_css;
    w_din_nxt       = r_din;
    w_res_data_nxt  = r_res_data;
    w_res_ch_nxt    = r_res_ch;
    w_res_valid_nxt = 1'b0;
    w_scan_done     = 1'b0;
    w_first         = find_ch(ch_mask, 4'd0);
    w_next          = find_ch(r_mask, {1'b0, r_addr} + 4'd1);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_mask_nxt = ch_mask;
          w_gcnt_nxt = '0;
          if (w_first[3]) begin
            w_state_nxt = SETUP;
            w_addr_nxt  = w_first[2:0];
            w_hcnt_nxt  = '0;
            w_css_nxt   = 1'b0;
            w_din_nxt   = 1'b0;
          end else begin
            w_state_nxt = GAP;
          end
        end
      end
      SETUP: begin
        if (r_hcnt == HALF_LAST) begin
          w_state_nxt = SHIFT;
          w_hcnt_nxt  = '0;
          w_phase_nxt = 1'b0;
          w_bit_nxt   = 5'd1;
          w_sclk_nxt  = 1'b0;
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      SHIFT: begin
        if (r_hcnt != HALF_LAST) begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end else begin
          w_hcnt_nxt = '0;
          if (!r_phase) begin
            // Rising edge k: sample data and present din for falling edge k+1.
            w_phase_nxt = 1'b1;
            w_sclk_nxt  = 1'b1;
            case (r_bit)
              5'd2:    w_din_nxt = r_addr[2];
              5'd3:    w_din_nxt = r_addr[1];
              5'd4:    w_din_nxt = r_addr[0];
              default: w_din_nxt = 1'b0;
            endcase
            if (r_bit >= 5'd5) w_shift_nxt = {r_shift[ADC_W-2:0], adc_dout};
          end else if (r_bit == BIT_LAST) begin
            w_state_nxt     = GAP;
            w_gcnt_nxt      = '0;
            w_css_nxt       = 1'b1;
            w_din_nxt       = 1'b0;
            w_res_valid_nxt = 1'b1;
            w_res_data_nxt  = r_shift;
            w_res_ch_nxt    = r_addr;
          end else begin
            w_phase_nxt = 1'b0;
            w_sclk_nxt  = 1'b0;
            w_bit_nxt   = r_bit + 5'd1;
          end
        end
      end
      GAP: begin
        if (r_gcnt != GAP_LAST) begin
          w_gcnt_nxt = r_gcnt + 1'b1;
        end else if (w_next[3]) begin
          w_state_nxt = SETUP;
          w_addr_nxt  = w_next[2:0];
          w_hcnt_nxt  = '0;
          w_css_nxt   = 1'b0;
          w_din_nxt   = 1'b0;
        end else begin
          w_scan_done = 1'b1;
          w_state_nxt = IDLE;
          w_mask_nxt  = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hcnt      <= '0;
      r_phase     <= 1'b0;
      r_bit       <= '0;
      r_gcnt      <= '0;
      r_mask      <= '0;
      r_addr      <= '0;
      r_shift     <= '0;
      r_sclk      <= 1'b1;
      r_css       <= 1'b1;
      r_din       <= 1'b0;
      r_res_data  <= '0;
      r_res_ch    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hcnt      <= w_hcnt_nxt;
      r_phase     <= w_phase_nxt;
      r_bit       <= w_bit_nxt;
      r_gcnt      <= w_gcnt_nxt;
      r_mask      <= w_mask_nxt;
      r_addr      <= w_addr_nxt;
      r_shift     <= w_shift_nxt;
      r_sclk      <= w_sclk_nxt;
      r_css       <= w_css_nxt;
      r_din       <= w_din_nxt;
      r_res_data  <= w_res_data_nxt;
      r_res_ch    <= w_res_ch_nxt;
      r_res_valid <= w_res_valid_nxt;
    end
  end

  assign busy      = (r_state != IDLE);
  assign adc_sclk  = r_sclk;
  assign adc_css   = r_css;
  assign adc_din   = r_din;
  assign res_data  = r_res_data;
  assign res_ch    = r_res_ch;
  assign res_valid = r_res_valid;
  assign scan_done = w_scan_done;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - directed self-checking bench for adc_scan_ctrl
module tb_adc_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        busy, adc_sclk, adc_css, adc_din;
  logic        adc_dout = 1'b0;
  logic [11:0] res_data;
  logic [2:0]  res_ch;
  logic        res_valid, scan_done;

  adc_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .busy(busy),
    .adc_sclk(adc_sclk), .adc_css(adc_css), .adc_din(adc_din), .adc_dout(adc_dout),
    .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ADC model: address from din at falling edges 3..5, data MSB-first from falling edge 5.
  logic [11:0] adc_mem [8];
  int          m_k = 0;
  logic [2:0]  m_addr = 3'd0;
  logic [4:0]  din_seq = 5'd0;
  always @(negedge adc_sclk or negedge adc_css) begin
    if (adc_sclk) begin
      m_k = 0;
      din_seq = 5'd0;
    end else begin
      m_k++;
      if (m_k <= 5) din_seq = {din_seq[3:0], adc_din};
      if (m_k >= 3 && m_k <= 5) m_addr = {m_addr[1:0], adc_din};
      if (m_k >= 5 && m_k <= 16) adc_dout = adc_mem[m_addr][16 - m_k];
    end
  end

  logic        mon_clr = 1'b1;
  logic        prev_css = 1'b1, prev_sclk = 1'b1;
  int          frames, css_falls, bad_win, bad_fall, gap_min, done_cnt;
  int          rv_cyc, done_cyc, win_len, fall_cnt, gap_len;
  int          cyc = 0;
  logic [14:0] rv_q[$];
  always @(negedge clk) begin
    if (mon_clr) begin
      frames = 0; css_falls = 0; bad_win = 0; bad_fall = 0; gap_min = 99; done_cnt = 0;
      rv_cyc = 0; done_cyc = 0; win_len = 0; fall_cnt = 0; gap_len = 0;
      prev_css = 1'b1; prev_sclk = 1'b1;
      rv_q.delete();
    end else begin
      if (res_valid) begin
        rv_q.push_back({res_ch, res_data});
        rv_cyc = cyc;
      end
      if (scan_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!adc_css) begin
        if (prev_css) begin
          css_falls++;
          if (frames > 0 && gap_len < gap_min) gap_min = gap_len;
          win_len = 0;
          fall_cnt = 0;
        end
        win_len++;
        if (prev_sclk && !adc_sclk) fall_cnt++;
      end else begin
        if (!prev_css) begin
          frames++;
          if (win_len != 132) bad_win++;
          if (fall_cnt != 16) bad_fall++;
          gap_len = 0;
        end
        gap_len++;
      end
      prev_css = adc_css;
      prev_sclk = adc_sclk;
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(posedge clk);
    #1 ch_mask = m; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (scan_done) got = 1'b1;
    end
    check(tag, 32'(got), 32'd1);
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_scan(input logic [7:0] m, input string tag);
    pulse_start(m);
    check({tag, "_busy_set"}, 32'(busy), 32'd1);
    wait_done(tag);
  endtask

  task automatic check_full_scan(input string tag);
    check({tag, "_frames"}, 32'(frames), 32'd8);
    check({tag, "_rv_count"}, 32'(rv_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_ch"}, 32'(rv_q[i][14:12]), 32'(i));
      check({tag, "_data"}, 32'(rv_q[i][11:0]), 32'(12'(12'h101 * i)));
    end
  endtask

  initial begin
    logic got;
    for (int i = 0; i < 8; i++) adc_mem[i] = 12'(12'h101 * i);
    repeat (3) @(negedge clk);
    check("rst_css", 32'(adc_css), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_din", 32'(adc_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_ch", 32'(res_ch), 32'd0);
    rst_n = 1'b1;

    adc_mem[5] = 12'hA5C;
    clr_mon();
    run_scan(8'h20, "ch5");
    check("ch5_frames", 32'(frames), 32'd1);
    check("ch5_rv_count", 32'(rv_q.size()), 32'd1);
    check("ch5_res_ch", 32'(rv_q[0][14:12]), 32'd5);
    check("ch5_res_data", 32'(rv_q[0][11:0]), 32'hA5C);
    check("ch5_din_seq", 32'(din_seq), 32'b00101);
    check("ch5_done_delay", 32'(done_cyc - rv_cyc), 32'd1);
    check("ch5_win_len", 32'(bad_win), 32'd0);
    check("ch5_sclk_falls", 32'(bad_fall), 32'd0);
    adc_mem[5] = 12'h505;

    clr_mon();
    run_scan(8'hFF, "all");
    check_full_scan("all");
    check("all_win_len", 32'(bad_win), 32'd0);
    check("all_sclk_falls", 32'(bad_fall), 32'd0);
    check("all_gap_min", 32'(gap_min), 32'd2);

    clr_mon();
    run_scan(8'h00, "empty");
    check("empty_css_falls", 32'(css_falls), 32'd0);
    check("empty_done_cnt", 32'(done_cnt), 32'd1);
    check("empty_rv_count", 32'(rv_q.size()), 32'd0);
    clr_mon();
    run_scan(8'h02, "after_empty");
    check("after_empty_rv_count", 32'(rv_q.size()), 32'd1);
    check("after_empty_ch", 32'(rv_q[0][14:12]), 32'd1);
    check("after_empty_data", 32'(rv_q[0][11:0]), 32'h101);

    adc_mem[0] = 12'hFFF;
    adc_mem[7] = 12'h000;
    clr_mon();
    run_scan(8'h81, "edge");
    check("edge_rv_count", 32'(rv_q.size()), 32'd2);
    check("edge_first", 32'(rv_q[0]), 32'({3'd0, 12'hFFF}));
    check("edge_second", 32'(rv_q[1]), 32'({3'd7, 12'h000}));
    adc_mem[0] = 12'h000;
    adc_mem[7] = 12'h707;

    clr_mon();
    pulse_start(8'h15);
    #1 ch_mask = 8'hFF;
    repeat (150) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; ch_mask = 8'h0A;
    wait_done("midscan");
    check("midscan_rv_count", 32'(rv_q.size()), 32'd3);
    check("midscan_first", 32'(rv_q[0]), 32'({3'd0, 12'h000}));
    check("midscan_second", 32'(rv_q[1]), 32'({3'd2, 12'h202}));
    check("midscan_third", 32'(rv_q[2]), 32'({3'd4, 12'h404}));

    clr_mon();
    pulse_start(8'hFF);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (frames == 2 && !adc_css) got = 1'b1;
    end
    check("rst_frame3_reached", 32'(got), 32'd1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_css", 32'(adc_css), 32'd1);
    check("midrst_sclk", 32'(adc_sclk), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_din", 32'(adc_din), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_rv_count", 32'(rv_q.size()), 32'd2);
    check("midrst_res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    clr_mon();
    run_scan(8'hFF, "post_rst");
    check_full_scan("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
